// File: rtl/mdio_phy_responder_if.sv
// rtl/mdio_phy_responder_if.sv - MDIO pad signals and write/error strobes between MAC side and PHY responder
interface mdio_phy_responder_if;
   logic        mdc;
   logic        mdio_in;
   logic        mdio_out;
   logic        mdio_oen;
   logic        wr_pulse;
   logic [4:0]  wr_addr;
   logic [15:0] wr_data;
   logic        frame_err;

   modport master (
      output mdc,
      output mdio_in,
      input  mdio_out,
      input  mdio_oen,
      input  wr_pulse,
      input  wr_addr,
      input  wr_data,
      input  frame_err
   );

   modport slave (
      input  mdc,
      input  mdio_in,
      output mdio_out,
      output mdio_oen,
      output wr_pulse,
      output wr_addr,
      output wr_data,
      output frame_err
   );
endinterface

// File: rtl/mdio_phy_responder.sv
// rtl/mdio_phy_responder.sv - Clause-22 MDIO PHY-side responder with 32 x 16-bit register file
module mdio_phy_responder #(
   parameter logic [4:0]  PHY_ADDR = 5'd0,
   parameter int          PRE_BITS = 32,
   parameter logic [15:0] ID1      = 16'h0141,
   parameter logic [15:0] ID2      = 16'h0CC2
) (
   input logic                 clkin_50,
   input logic                 reset,
   mdio_phy_responder_if.slave mif
);

   typedef enum logic [3:0] {
      S_IDLE, S_ST2, S_OP1, S_OP2, S_PHYAD, S_REGAD, S_TA1, S_TA2, S_DATA
   } state_t;

   state_t      state, state_n;
   logic        mdc_s1, mdc_s2, mdc_prev;
   logic        mdio_s1, mdio_s2;
   logic        mdc_rise;
   logic        mdio_bit;
   logic [5:0]  pre_cnt;
   logic [3:0]  bit_cnt;
   logic        op_rd;
   logic        phy_match;
   logic        rd_act;
   logic [3:0]  addr_sr;
   logic [4:0]  addr_full;
   logic [4:0]  regad;
   logic [15:0] rd_sr;
   logic [15:0] rd_value;
   logic [14:0] wr_sr;
   logic [15:0] data_full;
   logic        err_n;
   logic        oen_r, out_r;
   logic        wr_pulse_r;
   logic [4:0]  wr_addr_r;
   logic [15:0] wr_data_r;
   logic        frame_err_r;
   logic [15:0] regs [32];

   assign mdc_rise  = mdc_s2 & ~mdc_prev;
   assign mdio_bit  = mdio_s2;
   assign addr_full = {addr_sr, mdio_bit};
   assign data_full = {wr_sr, mdio_bit};
   assign rd_act    = op_rd & phy_match;

   // reset gates the pad driver directly so a mid-frame reset frees the bus at once
   assign mif.mdio_oen  = oen_r | reset;
   assign mif.mdio_out  = out_r | reset;
   assign mif.wr_pulse  = wr_pulse_r;
   assign mif.wr_addr   = wr_addr_r;
   assign mif.wr_data   = wr_data_r;
   assign mif.frame_err = frame_err_r;

   // two-flop synchronisers for the asynchronous MDC and MDIO pads, plus MDC history for edge detect
   always_ff @(posedge clkin_50) begin
      if (reset) begin
         mdc_s1   <= 1'b0;
         mdc_s2   <= 1'b0;
         mdc_prev <= 1'b0;
         mdio_s1  <= 1'b1;
         mdio_s2  <= 1'b1;
      end else begin
         mdc_s1   <= mif.mdc;
         mdc_s2   <= mdc_s1;
         mdc_prev <= mdc_s2;
         mdio_s1  <= mif.mdio_in;
         mdio_s2  <= mdio_s1;
      end
   end

   // register (or ID constant) selected by the REGAD value completing on this edge
   always_comb begin
      rd_value = regs[addr_full];
      if (addr_full == 5'd2) rd_value = ID1;
      if (addr_full == 5'd3) rd_value = ID2;
   end

   // frame sequencing: advance one field position per detected MDC rising edge
   always_comb begin
      state_n = state;
      err_n   = 1'b0;
      if (mdc_rise) begin
         case (state)
            S_IDLE:  if (!mdio_bit && pre_cnt == 6'(PRE_BITS)) state_n = S_ST2;
            S_ST2:   begin
                        if (mdio_bit) state_n = S_OP1;
                        else begin
                           err_n   = 1'b1;
                           state_n = S_IDLE;
                        end
                     end
            S_OP1:   state_n = S_OP2;
            S_OP2:   begin
                        if (op_rd != mdio_bit) state_n = S_PHYAD;
                        else begin
                           err_n   = 1'b1;
                           state_n = S_IDLE;
                        end
                     end
            S_PHYAD: if (bit_cnt == 4'd4) state_n = S_REGAD;
            S_REGAD: if (bit_cnt == 4'd4) state_n = S_TA1;
            S_TA1:   state_n = S_TA2;
            S_TA2:   state_n = S_DATA;
            S_DATA:  if (bit_cnt == 4'd15) state_n = S_IDLE;
            default: state_n = S_IDLE;
         endcase
      end
   end

   // field capture, read-data drive, write commit and register file; all updates on MDC edge cycles
   always_ff @(posedge clkin_50) begin
      if (reset) begin
         state       <= S_IDLE;
         pre_cnt     <= 6'd0;
         bit_cnt     <= 4'd0;
         op_rd       <= 1'b0;
         phy_match   <= 1'b0;
         addr_sr     <= 4'd0;
         regad       <= 5'd0;
         rd_sr       <= 16'h0000;
         wr_sr       <= 15'h0000;
         oen_r       <= 1'b1;
         out_r       <= 1'b1;
         wr_pulse_r  <= 1'b0;
         wr_addr_r   <= 5'd0;
         wr_data_r   <= 16'h0000;
         frame_err_r <= 1'b0;
         for (int i = 0; i < 32; i++) regs[i] <= 16'h0000;
      end else begin
         state       <= state_n;
         wr_pulse_r  <= 1'b0;
         frame_err_r <= err_n;
         if (mdc_rise) begin
            case (state)
               S_IDLE: begin
                  if (mdio_bit) begin
                     if (pre_cnt != 6'(PRE_BITS)) pre_cnt <= pre_cnt + 6'd1;
                  end else begin
                     pre_cnt <= 6'd0;
                  end
               end
               S_OP1: op_rd <= mdio_bit;
               S_OP2: bit_cnt <= 4'd0;
               S_PHYAD: begin
                  addr_sr <= addr_full[3:0];
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd4) begin
                     phy_match <= (addr_full == PHY_ADDR);
                     bit_cnt   <= 4'd0;
                  end
               end
               S_REGAD: begin
                  addr_sr <= addr_full[3:0];
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd4) begin
                     regad   <= addr_full;
                     rd_sr   <= rd_value;
                     bit_cnt <= 4'd0;
                  end
               end
               S_TA1: begin
                  if (rd_act) begin
                     oen_r <= 1'b0;
                     out_r <= 1'b0;
                  end
               end
               S_TA2: begin
                  bit_cnt <= 4'd0;
                  if (rd_act) begin
                     out_r <= rd_sr[15];
                     rd_sr <= {rd_sr[14:0], 1'b0};
                  end
               end
               S_DATA: begin
                  bit_cnt <= bit_cnt + 4'd1;
                  wr_sr   <= data_full[14:0];
                  if (rd_act) begin
                     if (bit_cnt == 4'd15) begin
                        oen_r <= 1'b1;
                        out_r <= 1'b1;
                     end else begin
                        out_r <= rd_sr[15];
                        rd_sr <= {rd_sr[14:0], 1'b0};
                     end
                  end
                  if (bit_cnt == 4'd15 && !op_rd && phy_match) begin
                     wr_pulse_r <= 1'b1;
                     wr_addr_r  <= regad;
                     wr_data_r  <= data_full;
                     if (regad != 5'd2 && regad != 5'd3)
                        regs[regad] <= (regad == 5'd0) ? {1'b0, data_full[14:0]} : data_full;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// tb/tb_mdio_phy_responder.sv - randomized and directed bench for mdio_phy_responder against a bit-stream model
module tb_mdio_phy_responder;

   localparam int         PRE = 32;
   localparam logic [4:0] PHY = 5'd0;

   typedef struct {
      logic [4:0]  a;
      logic [15:0] d;
   } wr_t;

   logic clkin_50 = 1'b0;
   logic reset;

   always #10 clkin_50 = ~clkin_50;

   mdio_phy_responder_if mif ();

   mdio_phy_responder #(
      .PHY_ADDR (PHY),
      .PRE_BITS (PRE),
      .ID1      (16'h0141),
      .ID2      (16'h0CC2)
   ) dut (
      .clkin_50 (clkin_50),
      .reset    (reset),
      .mif      (mif)
   );

   int          tests;
   int          fails;
   bit          s_bits [$];
   bit          e_oen [$];
   bit          e_out [$];
   wr_t         exp_wr [$];
   int          exp_err;
   int          err_seen;
   int          wr_seen;
   int          oen_low;
   logic [15:0] m_regs [32];
   int          m_ones;
   logic [15:0] cap_rd;
   logic [4:0]  last_wa;
   logic [15:0] last_wd;
   bit          chk_req;
   int          chk_idx;
   bit          done;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] model_read(input logic [4:0] a);
      if (a == 5'd2) return 16'h0141;
      if (a == 5'd3) return 16'h0CC2;
      return m_regs[a];
   endfunction

   task automatic push_bits(input logic [31:0] v, input int n);
      for (int k = n - 1; k >= 0; k--) s_bits.push_back(v[k]);
   endtask

   task automatic add_frame(input int pre, input logic [1:0] st, input logic [1:0] op,
                            input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] d);
      repeat (pre) s_bits.push_back(1'b1);
      push_bits(32'(st), 2);
      push_bits(32'(op), 2);
      if (st == 2'b01 && (op == 2'b10 || op == 2'b01)) begin
         push_bits(32'(phy), 5);
         push_bits(32'(ra), 5);
         if (op == 2'b10) repeat (18) s_bits.push_back(1'b1);
         else begin
            push_bits(32'h2, 2);
            push_bits(32'(d), 16);
         end
      end
   endtask

   // walks the whole bit stream as the MAC would frame it and records what the bus must show at each edge
   task automatic walk();
      int          n;
      int          i;
      logic [1:0]  op;
      logic [4:0]  phy;
      logic [4:0]  ra;
      logic [15:0] v;
      wr_t         w;
      n = s_bits.size();
      i = 0;
      exp_err = 0;
      e_oen.delete();
      e_out.delete();
      for (int k = 0; k < n; k++) begin
         e_oen.push_back(1'b1);
         e_out.push_back(1'b1);
      end
      while (i < n) begin
         if (s_bits[i]) begin
            if (m_ones < PRE) m_ones++;
            i++;
         end else if (m_ones < PRE) begin
            m_ones = 0;
            i++;
         end else begin
            m_ones = 0;
            if (i + 3 >= n) i = n;
            else if (!s_bits[i+1]) begin
               exp_err++;
               i += 2;
            end else begin
               op = {s_bits[i+2], s_bits[i+3]};
               if (op != 2'b10 && op != 2'b01) begin
                  exp_err++;
                  i += 4;
               end else if (i + 31 >= n) i = n;
               else begin
                  phy = 5'd0;
                  ra  = 5'd0;
                  for (int k = 0; k < 5; k++) begin
                     phy = {phy[3:0], s_bits[i+4+k]};
                     ra  = {ra[3:0], s_bits[i+9+k]};
                  end
                  if (phy == PHY) begin
                     if (op == 2'b10) begin
                        v = model_read(ra);
                        e_oen[i+15] = 1'b0;
                        e_out[i+15] = 1'b0;
                        for (int k = 0; k < 16; k++) begin
                           e_oen[i+16+k] = 1'b0;
                           e_out[i+16+k] = v[15-k];
                        end
                     end else begin
                        v = 16'h0000;
                        for (int k = 0; k < 16; k++) v = {v[14:0], s_bits[i+16+k]};
                        w.a = ra;
                        w.d = v;
                        exp_wr.push_back(w);
                        if (ra != 5'd2 && ra != 5'd3) m_regs[ra] = (ra == 5'd0) ? (v & 16'h7FFF) : v;
                     end
                  end
                  i += 32;
               end
            end
         end
      end
   endtask

   task automatic play(input int limit);
      for (int j = 0; j < limit; j++) begin
         mif.mdio_in = s_bits[j];
         repeat ($urandom_range(6, 4)) @(posedge clkin_50);
         #1;
         chk_idx = j;
         chk_req = 1'b1;
         @(posedge clkin_50);
         #1 mif.mdc = 1'b1;
         repeat ($urandom_range(6, 4)) @(posedge clkin_50);
         #1 mif.mdc = 1'b0;
      end
   endtask

   task automatic run_stream();
      s_bits.push_back(1'b0);
      walk();
      err_seen = 0;
      wr_seen  = 0;
      oen_low  = 0;
      play(s_bits.size());
      repeat (4) @(posedge clkin_50);
      check("pending_writes", exp_wr.size(), 0);
      check("frame_err_count", err_seen, exp_err);
      exp_wr.delete();
      s_bits.delete();
   endtask

   task automatic compare_loop();
      wr_t w;
      while (!done) begin
         @(negedge clkin_50);
         if (chk_req) begin
            chk_req = 1'b0;
            check($sformatf("bus_oen[%0d]", chk_idx), mif.mdio_oen, e_oen[chk_idx]);
            check($sformatf("bus_out[%0d]", chk_idx), mif.mdio_out, e_out[chk_idx]);
            if (mif.mdio_oen == 1'b0) begin
               oen_low++;
               cap_rd = {cap_rd[14:0], mif.mdio_out};
            end
         end
         if (mif.wr_pulse) begin
            wr_seen++;
            last_wa = mif.wr_addr;
            last_wd = mif.wr_data;
            check("wr_pulse_expected", (exp_wr.size() > 0), 1);
            if (exp_wr.size() > 0) begin
               w = exp_wr.pop_front();
               check("wr_addr", mif.wr_addr, w.a);
               check("wr_data", mif.wr_data, w.d);
            end
         end
         if (mif.frame_err) err_seen++;
      end
   endtask

   task automatic main_seq();
      logic [15:0] d7;
      int          r;
      logic [1:0]  st, op;
      logic [4:0]  phy;

      // write then read back an ordinary register
      add_frame(32, 2'b01, 2'b01, 5'd0, 5'd4, 16'hA5C3);
      run_stream();
      check("t1_wr_count", wr_seen, 1);
      check("t1_wr_addr", last_wa, 5'd4);
      check("t1_wr_data", last_wd, 16'hA5C3);
      add_frame(32, 2'b01, 2'b10, 5'd0, 5'd4, 16'h0000);
      run_stream();
      check("t1_read_reg4", cap_rd, 16'hA5C3);
      check("t1_drive_bits", oen_low, 17);

      // identifier registers
      add_frame(32, 2'b01, 2'b10, 5'd0, 5'd2, 16'h0000);
      run_stream();
      check("t2_read_id1", cap_rd, 16'h0141);
      add_frame(32, 2'b01, 2'b10, 5'd0, 5'd3, 16'h0000);
      run_stream();
      check("t2_read_id2", cap_rd, 16'h0CC2);

      // control register bit 15 self-clears
      add_frame(32, 2'b01, 2'b01, 5'd0, 5'd0, 16'h8000);
      run_stream();
      check("t3_wr_data", last_wd, 16'h8000);
      add_frame(32, 2'b01, 2'b10, 5'd0, 5'd0, 16'h0000);
      run_stream();
      check("t3_read_reg0", cap_rd, 16'h0000);

      // other PHY address: silent
      add_frame(32, 2'b01, 2'b01, 5'd3, 5'd5, 16'h1234);
      add_frame(32, 2'b01, 2'b10, 5'd3, 5'd2, 16'h0000);
      run_stream();
      check("t4_no_write", wr_seen, 0);
      check("t4_no_drive", oen_low, 0);
      check("t4_no_err", err_seen, 0);

      // short preamble ignored; bad opcode aborts; next frame answered
      add_frame(31, 2'b01, 2'b10, 5'd0, 5'd2, 16'h0000);
      run_stream();
      check("t5_short_pre_no_drive", oen_low, 0);
      check("t5_short_pre_no_err", err_seen, 0);
      add_frame(32, 2'b01, 2'b11, 5'd0, 5'd2, 16'h0000);
      add_frame(32, 2'b01, 2'b10, 5'd0, 5'd3, 16'h0000);
      run_stream();
      check("t5_op11_err", err_seen, 1);
      check("t5_next_read", cap_rd, 16'h0CC2);
      check("t5_next_drive_bits", oen_low, 17);

      // reset in the middle of a read data phase
      add_frame(32, 2'b01, 2'b10, 5'd0, 5'd4, 16'h0000);
      walk();
      play(57);
      repeat (4) @(posedge clkin_50);
      #1 check("t6_driving_before_reset", mif.mdio_oen, 1'b0);
      @(posedge clkin_50);
      #1 reset = 1'b1;
      @(negedge clkin_50);
      check("t6_oen_in_reset", mif.mdio_oen, 1'b1);
      @(posedge clkin_50);
      #1 reset = 1'b0;
      @(negedge clkin_50);
      check("t6_oen_after_reset", mif.mdio_oen, 1'b1);
      check("t6_out_after_reset", mif.mdio_out, 1'b1);
      s_bits.delete();
      exp_wr.delete();
      m_ones = 0;
      for (int k = 0; k < 32; k++) m_regs[k] = 16'h0000;
      add_frame(32, 2'b01, 2'b10, 5'd0, 5'd4, 16'h0000);
      run_stream();
      check("t6_reg4_cleared", cap_rd, 16'h0000);
      d7 = 16'($urandom);
      add_frame(32, 2'b01, 2'b01, 5'd0, 5'd7, d7);
      add_frame(32, 2'b01, 2'b10, 5'd0, 5'd7, 16'h0000);
      run_stream();
      check("t6_write_after_reset", wr_seen, 1);
      check("t6_readback", cap_rd, d7);

      // randomized frame mix
      for (int s = 0; s < 3; s++) begin
         for (int f = 0; f < 10; f++) begin
            r   = $urandom_range(9, 0);
            phy = ($urandom_range(2, 0) == 0) ? 5'($urandom_range(31, 1)) : PHY;
            st  = 2'b01;
            if (r < 4) op = 2'b01;
            else if (r < 8) op = 2'b10;
            else if (r == 8) op = ($urandom_range(1, 0) == 0) ? 2'b00 : 2'b11;
            else begin
               op = 2'b10;
               st = 2'b00;
            end
            add_frame(PRE + $urandom_range(3, 0), st, op, phy, 5'($urandom), 16'($urandom));
         end
         run_stream();
      end
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      reset    = 1'b1;
      mif.mdc  = 1'b0;
      mif.mdio_in = 1'b1;
      chk_req  = 1'b0;
      chk_idx  = 0;
      done     = 1'b0;
      m_ones   = 0;
      cap_rd   = 16'h0000;
      exp_err  = 0;
      err_seen = 0;
      wr_seen  = 0;
      oen_low  = 0;
      for (int k = 0; k < 32; k++) m_regs[k] = 16'h0000;
      repeat (3) @(posedge clkin_50);
      #1 reset = 1'b0;
      @(negedge clkin_50);
      check("rst_oen", mif.mdio_oen, 1'b1);
      check("rst_out", mif.mdio_out, 1'b1);
      check("rst_wr_pulse", mif.wr_pulse, 1'b0);
      check("rst_wr_addr", mif.wr_addr, 5'd0);
      check("rst_wr_data", mif.wr_data, 16'h0000);
      check("rst_frame_err", mif.frame_err, 1'b0);
      fork
         compare_loop();
         begin
            main_seq();
            done = 1'b1;
         end
      join
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
